// File: rtl/bch_encode_stream.sv
// bch_encode_stream: systematic BCH encoder, data beats pass through, then the g(x) remainder as parity beats.
// Define BCH_ENC_PARITY_INVERT_EN to send parity inverted (pad bits stay 0). P = {DATA_BITS(0=full), T, M}.
module bch_encode_stream #(
  parameter logic [31:0] P = 32'h000b_0104,
  parameter int BITS = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_first,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_first,
  output logic            out_last,
  output logic            out_parity
);
  function automatic int prim_of(input int m);
    case (m)
      2: return 'h7;
      3: return 'hB;
      4: return 'h13;
      5: return 'h25;
      6: return 'h43;
      7: return 'h89;
      8: return 'h11D;
      9: return 'h211;
      10: return 'h409;
      11: return 'h805;
      12: return 'h1053;
      13: return 'h201B;
      14: return 'h4443;
      15: return 'h8003;
      16: return 'h1100B;
      default: return 0;
    endcase
  endfunction
  function automatic int gf_mul(input int a, input int b, input int m);
    int r;
    r = 0;
    for (int i = 0; i < m; i++) begin
      if (b[i]) r ^= a;
      a = a << 1;
      if (a[m]) a ^= prim_of(m);
    end
    return r;
  endfunction
  function automatic int alpha_pow(input int e, input int m);
    int a;
    a = 1;
    for (int k = 0; k < e; k++) a = gf_mul(a, 2, m);
    return a;
  endfunction
  // g(x) = product of the minimal polynomials of alpha^1, alpha^3, ..., alpha^(2T-1), each coset once
  function automatic logic [255:0] gen_poly(input int m, input int t);
    int n, j, e, mn, deg, ae;
    int c[17];
    bit done;
    logic [255:0] gp, mp, r;
    n = (1 << m) - 1;
    gp = 256'd1;
    for (int i = 1; i <= t; i++) begin
      j = (2 * i - 1) % n;
      mn = j;
      e = j;
      for (int k = 1; k < m; k++) begin
        e = (e * 2) % n;
        if (e < mn) mn = e;
      end
      if (mn == j) begin
        for (int k = 0; k < 17; k++) c[k] = 0;
        c[0] = 1;
        deg = 0;
        e = j;
        done = 0;
        for (int k = 0; k < m; k++) if (!done) begin
          ae = alpha_pow(e, m);
          for (int s = deg + 1; s > 0; s--) c[s] = c[s-1] ^ gf_mul(c[s], ae, m);
          c[0] = gf_mul(c[0], ae, m);
          deg++;
          e = (e * 2) % n;
          done = (e == j);
        end
        mp = '0;
        for (int k = 0; k <= deg; k++) mp[k] = c[k][0];
        r = '0;
        for (int k = 0; k <= m; k++) if (mp[k]) r ^= gp << k;
        gp = r;
      end
    end
    return gp;
  endfunction
  function automatic int poly_deg(input logic [255:0] g);
    int d;
    d = 0;
    for (int k = 0; k < 256; k++) if (g[k]) d = k;
    return d;
  endfunction
  localparam int M = int'(P[7:0]);
  localparam int T = int'(P[15:8]);
  localparam logic [255:0] G = gen_poly(M, T);
  localparam int E = poly_deg(G);
  localparam int N = (1 << M) - 1;
  localparam int DATA_BITS = (P[31:16] == 16'd0) ? N - E : int'(P[31:16]);
  localparam int DBEATS = DATA_BITS / BITS;
  localparam int PBEATS = (E + BITS - 1) / BITS;
  localparam int PW = PBEATS * BITS;
  localparam int CW = $clog2((DBEATS > PBEATS ? DBEATS : PBEATS) + 1);
  localparam logic [E-1:0] GP = G[E-1:0];
  if (DATA_BITS % BITS != 0) begin : g_bad_bits
    $error("DATA_BITS must be a multiple of BITS");
  end
  function automatic logic [E-1:0] step(input logic [E-1:0] r, input logic [BITS-1:0] d);
    logic fb;
    for (int b = BITS - 1; b >= 0; b--) begin
      fb = r[E-1] ^ d[b];
      r = (r << 1) ^ ({E{fb}} & GP);
    end
    return r;
  endfunction
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  state_t state, state_n;
  logic [E-1:0] lfsr, lfsr_n;
  logic [CW-1:0] cnt, cnt_n, c;
  logic [BITS-1:0] data_n, pbeat;
  logic [PW-1:0] pext;
  logic valid_n, first_n, last_n, par_n, advance, plast;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance && state != PARITY;
  assign c = in_first ? CW'(1) : cnt + CW'(1);
  assign plast = cnt == CW'(PBEATS - 1);
  // left-align the remainder so the last beat is zero padded in its LSBs
  assign pext = PW'(lfsr) << (PW - E);
`ifdef BCH_ENC_PARITY_INVERT_EN
  localparam logic [PW-1:0] PMASK = {PW{1'b1}} << (PW - E);
  logic [PW-1:0] pm;
  assign pm = PMASK << (cnt * BITS);
  assign pbeat = pext[PW-1 -: BITS] ^ pm[PW-1 -: BITS];
`else
  assign pbeat = pext[PW-1 -: BITS];
`endif
  always_comb begin
    state_n = state;
    lfsr_n = lfsr;
    cnt_n = cnt;
    valid_n = out_valid;
    data_n = out_data;
    first_n = out_first;
    last_n = out_last;
    par_n = out_parity;
    if (advance) begin
      valid_n = 1'b0;
      first_n = 1'b0;
      last_n = 1'b0;
      par_n = 1'b0;
      if (state == PARITY) begin
        valid_n = 1'b1;
        par_n = 1'b1;
        data_n = pbeat;
        last_n = plast;
        lfsr_n = lfsr << BITS;
        cnt_n = plast ? '0 : cnt + CW'(1);
        state_n = plast ? IDLE : PARITY;
      end else if (in_valid && (in_first || state == DATA)) begin
        valid_n = 1'b1;
        data_n = in_data;
        first_n = in_first;
        lfsr_n = step(in_first ? '0 : lfsr, in_data);
        cnt_n = (c == CW'(DBEATS)) ? '0 : c;
        state_n = (c == CW'(DBEATS)) ? PARITY : DATA;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      lfsr <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      out_parity <= 1'b0;
    end else begin
      state <= state_n;
      lfsr <= lfsr_n;
      cnt <= cnt_n;
      out_valid <= valid_n;
      out_data <= data_n;
      out_first <= first_n;
      out_last <= last_n;
      out_parity <= par_n;
    end
endmodule
